// File: rtl/debug_trace_reader.sv
// debug_trace_reader
//
// Consumer end of the per-cycle commit debug interface. Every instruction
// committed while capturing is stored in a circular trace FIFO with a
// sequence tag and a flag marking non-sequential flow (anything other than
// previous PC + 4, plus the first commit after arm). An optional PC trigger
// freezes capture. A host drains the FIFO through a show-ahead valid/ready port.
//
// Ports
//   clk_i         system clock
//   rst_ni        asynchronous active-low reset
//   pc_i          committed PC
//   valid_inst_i  pc_i is a committed instruction this cycle
//   arm_i         pulse: flush FIFO, clear overflow/tag/counter, start capture
//   trig_en_i     enable freeze-on-PC trigger
//   trig_pc_i     trigger PC
//   rd_ready_i    host accepts the head entry
//   rd_valid_o    FIFO not empty
//   rd_pc_o       head entry PC
//   rd_tag_o      head entry sequence tag
//   rd_jump_o     head entry is non-sequential
//   count_o       entries held, 0..DEPTH
//   overflow_o    sticky: a commit was dropped since arm
//   state_o       00 idle, 01 capture, 10 frozen
//   inst_cnt_o    commits seen while capturing since arm

module debug_trace_reader #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned TAG_W = 8,
    parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [31:0]      pc_i,
    input  logic             valid_inst_i,
    input  logic             arm_i,
    input  logic             trig_en_i,
    input  logic [31:0]      trig_pc_i,
    input  logic             rd_ready_i,
    output logic             rd_valid_o,
    output logic [31:0]      rd_pc_o,
    output logic [TAG_W-1:0] rd_tag_o,
    output logic             rd_jump_o,
    output logic [CNT_W-1:0] count_o,
    output logic             overflow_o,
    output logic [1:0]       state_o,
    output logic [31:0]      inst_cnt_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] Full = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        StIdle    = 2'b00,
        StCapture = 2'b01,
        StFrozen  = 2'b10
    } state_e;

    state_e state_q, state_d;

    logic [31:0]      mem_pc   [DEPTH];
    logic [TAG_W-1:0] mem_tag  [DEPTH];
    logic             mem_jump [DEPTH];

    logic [PtrW-1:0]  wptr_q, wptr_d;
    logic [PtrW-1:0]  rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [31:0]      inst_cnt_q, inst_cnt_d;
    logic [31:0]      prev_pc_q, prev_pc_d;
    logic             first_q, first_d;

    logic not_empty;
    logic commit;
    logic pop;
    logic push;
    logic drop;
    logic trig_hit;
    logic entry_jump;

    assign not_empty = (count_q != '0);

    // arm wins over both a same-cycle commit and a same-cycle pop
    assign commit   = valid_inst_i && (state_q == StCapture) && !arm_i;
    assign pop      = not_empty && rd_ready_i && !arm_i;
    // when full, a same-cycle pop frees the slot the new entry takes
    assign push     = commit && ((count_q != Full) || pop);
    assign drop     = commit && !push;
    assign trig_hit = commit && trig_en_i && (pc_i == trig_pc_i);

    assign entry_jump = first_q || (pc_i != (prev_pc_q + 32'd4));

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (arm_i) state_d = StCapture;
            end
            StCapture: begin
                if (arm_i) begin
                    state_d = StCapture;
                end else if (trig_hit) begin
                    state_d = StFrozen;
                end
            end
            StFrozen: begin
                if (arm_i) state_d = StCapture;
            end
            default: state_d = StIdle;
        endcase
    end

    // Read data is forced to zero when empty so reset leaves all outputs at 0
    // without needing to reset the storage array.
    always_comb begin
        state_o    = state_q;
        rd_valid_o = not_empty;
        rd_pc_o    = '0;
        rd_tag_o   = '0;
        rd_jump_o  = 1'b0;
        if (not_empty) begin
            rd_pc_o   = mem_pc[rptr_q];
            rd_tag_o  = mem_tag[rptr_q];
            rd_jump_o = mem_jump[rptr_q];
        end
        count_o    = count_q;
        overflow_o = overflow_q;
        inst_cnt_o = inst_cnt_q;
    end

    // ------------------------------------------------------ FIFO control
    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        tag_d      = tag_q;
        inst_cnt_d = inst_cnt_q;
        prev_pc_d  = prev_pc_q;
        first_d    = first_q;

        if (arm_i) begin
            wptr_d     = '0;
            rptr_d     = '0;
            count_d    = '0;
            overflow_d = 1'b0;
            tag_d      = '0;
            inst_cnt_d = '0;
            first_d    = 1'b1;
        end else begin
            if (push) wptr_d = wptr_q + 1'b1;
            if (pop)  rptr_d = rptr_q + 1'b1;
            if (push && !pop) begin
                count_d = count_q + 1'b1;
            end else if (pop && !push) begin
                count_d = count_q - 1'b1;
            end
            if (drop) overflow_d = 1'b1;
            // tag and counter advance even on a drop so the gap shows the loss
            if (commit) begin
                tag_d      = tag_q + 1'b1;
                inst_cnt_d = inst_cnt_q + 32'd1;
                prev_pc_d  = pc_i;
                first_d    = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            tag_q      <= '0;
            inst_cnt_q <= '0;
            prev_pc_q  <= '0;
            first_q    <= 1'b1;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            tag_q      <= tag_d;
            inst_cnt_q <= inst_cnt_d;
            prev_pc_q  <= prev_pc_d;
            first_q    <= first_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_pc[wptr_q]   <= pc_i;
            mem_tag[wptr_q]  <= tag_q;
            mem_jump[wptr_q] <= entry_jump;
        end
    end

endmodule

// File: doc/debug_trace_reader.md
Name: debug_trace_reader

Overview:
Consumer end of the per-cycle commit debug interface (registered pc / valid_inst pair). Captures each committed instruction PC into a circular trace FIFO, tags it with a sequence number and a non-sequential-flow flag, and optionally freezes on a trigger PC. A host-side agent (test bench, debug UART bridge or logic analyser) drains the FIFO through a valid/ready read port.

Parameters:
DEPTH, 16, FIFO entries; power of two, >= 2
TAG_W, 8, width of per-entry sequence tag; wraps modulo 2^TAG_W
CNT_W, derived $clog2(DEPTH)+1, width of count_o

Ports:
clk_i  input  1  system clock
rst_ni  input  1  reset, asynchronous, active-low
pc_i  input  32  committed PC from debug register
valid_inst_i  input  1  pc_i is a committed instruction this cycle
arm_i  input  1  one-cycle pulse: flush FIFO, clear overflow/tag/counter, enter CAPTURE
trig_en_i  input  1  enable freeze-on-PC trigger
trig_pc_i  input  32  trigger PC
rd_ready_i  input  1  host accepts head entry
rd_valid_o  output  1  FIFO not empty
rd_pc_o  output  32  head entry PC (show-ahead)
rd_tag_o  output  TAG_W  head entry sequence tag
rd_jump_o  output  1  head entry is non-sequential
count_o  output  CNT_W  entries held, 0..DEPTH
overflow_o  output  1  sticky: at least one commit dropped since arm
state_o  output  2  00 IDLE, 01 CAPTURE, 10 FROZEN
inst_cnt_o  output  32  commits seen in CAPTURE since arm, wraps at 2^32

Behaviour:
- Reset (async assert, sync release): state IDLE, FIFO empty, rd_valid_o=0, rd_pc_o=0, rd_tag_o=0, rd_jump_o=0, count_o=0, overflow_o=0, inst_cnt_o=0, tag counter=0, prev-PC register=0, first-flag=1. Reset mid-capture discards all entries.
- Definitions: commit = valid_inst_i=1 while state=CAPTURE. pop = rd_valid_o & rd_ready_i.
- FSM:
  - IDLE --arm_i--> CAPTURE.
  - CAPTURE --(commit & trig_en_i & pc_i==trig_pc_i)--> FROZEN. The trigger entry itself is captured if there is room.
  - FROZEN --arm_i--> CAPTURE.
  - arm_i in CAPTURE restarts capture (flush).
  - arm_i has priority over a same-cycle commit: that commit is ignored.
- Arm effects (next edge): count=0, read/write pointers=0, overflow_o=0, tag=0, inst_cnt_o=0, first-flag=1. A pop in the same cycle is discarded.
- Commit effects:
  - inst_cnt_o+1.
  - tag+1 (entry receives the pre-increment tag).
  - prev-PC <= pc_i; first-flag <= 0.
  - Entry jump = first-flag | (pc_i != prev-PC + 32'd4), using 32-bit wrap arithmetic.
- Push: commit with count<DEPTH, or count==DEPTH with a same-cycle pop (slot freed).
- Full with no pop: entry dropped, overflow_o<=1 (sticky until arm/reset). Tag and inst_cnt still advance, so the tag gap exposes the loss.
- Latency: entry pushed at edge N appears on rd_* and in count_o after edge N (visible in cycle N+1). Pop at edge N advances the head in cycle N+1.
- Simultaneous push+pop: count unchanged; both pointers advance.
- Pointers wrap modulo DEPTH. count_o saturates structurally at DEPTH (never exceeds it).
- rd_pc_o/rd_tag_o/rd_jump_o hold the head entry while rd_valid_o=1 and rd_ready_i=0; they are don't-care when rd_valid_o=0.
- Reads are allowed in every state; FROZEN only stops pushes.
- Edge case: trigger with FIFO full and no pop: entry dropped, overflow set, state still goes to FROZEN.

Test Plan:
- Reset, arm, commit PCs 0x0,0x4,0x8 on consecutive cycles, rd_ready_i=0 -> count_o=3; head pc=0x0, tag=0, jump=1; then pop -> pc=0x4, tag=1, jump=0.
- Commits 0x100,0x104,0x200 -> third entry jump=1, tags 0,1,2; inst_cnt_o=3.
- DEPTH=16, 20 commits with no reads -> count_o=16, overflow_o=1, inst_cnt_o=20; drain gives tags 0..15. Then arm -> count_o=0, overflow_o=0.
- Full FIFO, commit and pop in same cycle -> count_o stays 16, overflow_o stays 0, last entry tag matches the new commit.
- trig_en_i=1, trig_pc_i=0x40, commits 0x38,0x3C,0x40,0x44 -> state_o=10 after 0x40; 3 entries held; 0x44 ignored; inst_cnt_o=3.
- Assert rst_ni low mid-capture with 5 entries -> all outputs 0 immediately, state_o=00; valid_inst_i pulses in IDLE capture nothing.
